audio_sample_feeder: RTL

AUDIO_SAMPLE_FEEDER -- requirements
Module: audio_sample_feeder

---
 rtl/audio_sample_feeder.sv | 96 +++++++++
 1 files changed

// File: rtl/audio_sample_feeder.sv
// rtl/audio_sample_feeder.sv - sample FIFO that feeds one volume-scaled PWM level per frame
// Frame counter, sample FIFO, per-frame pop with gain scaling and sticky underrun flag.
module audio_sample_feeder #(
   parameter int DEPTH      = 16,
   parameter int FRAME_BITS = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               vol,
   input  logic                     clr_underrun,
   output logic [7:0]               level,
   output logic                     frame_strobe,
   output logic [$clog2(DEPTH):0]   fill_count,
   output logic                     half_empty,
   output logic                     underrun
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [FRAME_BITS-1:0] frame_cnt;
   logic [7:0]            mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  frame_max;
   logic                  push;
   logic                  pop;
   logic [CW-1:0]         next_count;

   logic signed [11:0]    d_ext;
   logic signed [11:0]    g_ext;
   logic signed [11:0]    prod;
   logic signed [11:0]    prod_sh;
   logic [7:0]            scaled;

   assign frame_max = &frame_cnt;
   assign push      = in_valid && in_ready;
   assign pop       = frame_max && (fill_count != '0);

   always_comb begin
      next_count = fill_count;
      if (push && !pop)
         next_count = fill_count + CW'(1);
      else if (!push && pop)
         next_count = fill_count - CW'(1);
   end

   // Offset-binary to signed, multiply by vol+1, divide by 8, back to offset-binary.
   always_comb begin
      d_ext   = {{4{mem[rd_ptr][7] ^ 1'b1}}, ~mem[rd_ptr][7], mem[rd_ptr][6:0]};
      g_ext   = {8'd0, ({1'b0, vol} + 4'd1)};
      prod    = d_ext * g_ext;
      prod_sh = prod >>> 3;
      scaled  = {~prod_sh[7], prod_sh[6:0]};
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt    <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fill_count   <= '0;
         level        <= 8'h80;
         frame_strobe <= 1'b0;
         underrun     <= 1'b0;
         half_empty   <= 1'b1;
         in_ready     <= 1'b0;
      end else begin
         frame_cnt    <= frame_cnt + FRAME_BITS'(1);
         frame_strobe <= frame_max;
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         fill_count <= next_count;
         half_empty <= next_count < CW'(DEPTH / 2);
         in_ready   <= next_count != CW'(DEPTH);
         if (frame_max)
            level <= pop ? scaled : 8'h80;
         // A set on an empty frame boundary takes priority over a clear request.
         if (frame_max && fill_count == '0)
            underrun <= 1'b1;
         else if (clr_underrun)
            underrun <= 1'b0;
      end
   end

endmodule
